// File: rtl/wb_sram_pkg.sv
// Shared definitions for the banked Wishbone SRAM controller: bus widths,
// controller state encoding and the address-window mask helper.
package wb_sram_pkg;

  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    ACK
  } state_t;

  // The window covers every word of every bank, including unpopulated bank
  // indices, so the mask keeps only the address bits above that span.
  function automatic logic [31:0] window_mask(input int aw, input int bank_bits);
    logic [31:0] size;
    size = 32'd4 << (aw + bank_bits);
    return ~(size - 32'd1);
  endfunction

endpackage

// File: rtl/wb_sram_bank_mux.sv
// Remembers which bank the current request addressed and steers that bank's
// read data towards the controller's capture register.
module wb_sram_bank_mux
  import wb_sram_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_BITS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [BANK_BITS-1:0]       bank_in,
  input  logic [WB_DW*NUM_BANKS-1:0] dout,
  output logic [WB_DW-1:0]           rd_data
);

  logic [BANK_BITS-1:0] bank_q;

  // Hold the bank index of the accepted request until its data is captured
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= '0;
    end else if (load) begin
      bank_q <= bank_in;
    end
  end

  // Select the addressed macro; bank indices with no macro behind them read zero
  always_comb begin
    rd_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (int'(bank_q) == b) begin
        rd_data = dout[WB_DW*b +: WB_DW];
      end
    end
  end

endmodule

// File: rtl/wb_sram_banked_ctrl.sv
// Wishbone-classic slave mapping an aligned address window onto NUM_BANKS
// single-port SRAM macros. Every output is registered; the macro is enabled
// for exactly one cycle per transfer and read data is captured after the
// configured macro latency.
module wb_sram_banked_ctrl
  import wb_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          AW           = 10,
  parameter int          NUM_BANKS    = 2,
  parameter int          BANK_BITS    = 1,
  parameter int          READ_LATENCY = 1
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [WB_SW-1:0]           wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [WB_DW-1:0]           wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic [WB_DW-1:0]           wbs_dat_o,
  output logic [NUM_BANKS-1:0]       sram_csb_o,
  output logic                       sram_web_o,
  output logic [WB_SW-1:0]           sram_wmask_o,
  output logic [AW-1:0]              sram_addr_o,
  output logic [WB_DW-1:0]           sram_din_o,
  input  logic [WB_DW*NUM_BANKS-1:0] sram_dout_i
);

  localparam logic [31:0] WIN_MASK = window_mask(AW, BANK_BITS);
  localparam int          CW       = 2;

  state_t                state;
  logic [CW-1:0]         lat_cnt;
  logic                  is_read;
  logic                  void_q;
  logic                  hit;
  logic                  req;
  logic                  accept;
  logic                  bank_valid;
  logic [AW-1:0]         word;
  logic [BANK_BITS-1:0]  bank;
  logic [NUM_BANKS-1:0]  csb_sel;
  logic [WB_DW-1:0]      mux_data;

  assign hit        = (wbs_adr_i & WIN_MASK) == BASE_ADDR;
  assign req        = wbs_cyc_i & wbs_stb_i & hit;
  assign accept     = (state == IDLE) & req;
  assign word       = wbs_adr_i[AW+1:2];
  assign bank       = wbs_adr_i[AW+BANK_BITS+1:AW+2];
  assign bank_valid = int'(bank) < NUM_BANKS;

  // Active-low one-hot chip select for the addressed bank; all high for a void bank
  always_comb begin
    csb_sel = '1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (int'(bank) == b) begin
        csb_sel[b] = 1'b0;
      end
    end
  end

  wb_sram_bank_mux #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_BITS (BANK_BITS)
  ) u_bank_mux (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .load    (accept),
    .bank_in (bank),
    .dout    (sram_dout_i),
    .rd_data (mux_data)
  );

  // Transfer sequencer: accept, enable the macro for one cycle, wait out the
  // read latency, then acknowledge for one cycle; a dropped cyc abandons the ack
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      sram_csb_o   <= '1;
      sram_web_o   <= 1'b1;
      sram_wmask_o <= '0;
      sram_addr_o  <= '0;
      sram_din_o   <= '0;
      lat_cnt      <= '0;
      is_read      <= 1'b0;
      void_q       <= 1'b0;
    end else begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      sram_csb_o <= '1;
      case (state)
        IDLE: begin
          if (req) begin
            sram_addr_o  <= word;
            sram_din_o   <= wbs_dat_i;
            sram_wmask_o <= wbs_sel_i;
            sram_web_o   <= ~wbs_we_i;
            sram_csb_o   <= csb_sel;
            is_read      <= ~wbs_we_i;
            void_q       <= ~bank_valid;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (!wbs_cyc_i) begin
            state <= IDLE;
          end else if (!is_read || void_q) begin
            wbs_ack_o <= 1'b1;
            state     <= ACK;
          end else begin
            lat_cnt <= CW'(READ_LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (!wbs_cyc_i) begin
            state <= IDLE;
          end else if (lat_cnt == '0) begin
            wbs_dat_o <= mux_data;
            wbs_ack_o <= 1'b1;
            state     <= ACK;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_banked_ctrl.sv
// Bench for the banked Wishbone SRAM controller. Two controllers share one
// Wishbone bus: A uses the default configuration, B has three banks behind a
// two-bit bank field and a three-cycle macro. Behavioural macros sit behind
// each controller and a word-level reference memory predicts every response.
module tb_wb_sram_banked_ctrl;

  localparam logic [31:0] BASE_A = 32'h3000_0000;
  localparam logic [31:0] BASE_B = 32'h3002_0000;
  localparam int          RL_A   = 1;
  localparam int          RL_B   = 3;

  typedef struct {
    int          slave;
    logic        isRead;
    logic        voidAcc;
    logic [31:0] data;
    int          ackEdge;
    int          csbEdge;
    logic [2:0]  csbPat;
    logic [9:0]  word;
    logic [3:0]  mask;
    logic [31:0] din;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        initMem;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;

  logic        ackA, ackB, webA, webB;
  logic [31:0] datA, datB, dinA, dinB;
  logic [1:0]  csbA;
  logic [2:0]  csbB;
  logic [3:0]  maskA, maskB;
  logic [9:0]  addrA, addrB;
  logic [63:0] doutA;
  logic [95:0] doutB;

  int          cycleCount = 0;
  int          checks = 0;
  int          errors = 0;
  int          issueSeq = 0;
  exp_t        expQ[$];
  logic [31:0] refMem [logic [29:0]];

  int          obsCount [2];
  logic [2:0]  obsPat   [2];
  int          obsEdge  [2];
  logic [9:0]  obsWord  [2];
  logic [3:0]  obsMask  [2];
  logic        obsWeb   [2];
  logic [31:0] obsDin   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  wb_sram_banked_ctrl #(
    .BASE_ADDR(BASE_A), .AW(10), .NUM_BANKS(2), .BANK_BITS(1), .READ_LATENCY(RL_A)
  ) dutA (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ackA), .wbs_dat_o(datA),
    .sram_csb_o(csbA), .sram_web_o(webA), .sram_wmask_o(maskA), .sram_addr_o(addrA),
    .sram_din_o(dinA), .sram_dout_i(doutA)
  );

  wb_sram_banked_ctrl #(
    .BASE_ADDR(BASE_B), .AW(10), .NUM_BANKS(3), .BANK_BITS(2), .READ_LATENCY(RL_B)
  ) dutB (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ackB), .wbs_dat_o(datB),
    .sram_csb_o(csbB), .sram_web_o(webB), .sram_wmask_o(maskB), .sram_addr_o(addrB),
    .sram_din_o(dinB), .sram_dout_i(doutB)
  );

  // Behavioural macros: dout carries filler except when a read's data is due
  logic [31:0] memA [2][1024];
  logic [31:0] memB [3][1024];
  logic [31:0] rdA  [2];
  logic [31:0] pB0 [3], pB1 [3], pB2 [3];
  logic [31:0] junk;
  assign junk  = {16'hBAD0, cycleCount[15:0]};
  assign doutA = {rdA[1], rdA[0]};
  assign doutB = {pB2[2], pB2[1], pB2[0]};

  always @(posedge clk) begin
    if (initMem) begin
      for (int b = 0; b < 2; b++) for (int w = 0; w < 1024; w++) memA[b][w] <= '0;
      for (int b = 0; b < 3; b++) for (int w = 0; w < 1024; w++) memB[b][w] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        rdA[b] <= junk;
        if (csbA[b] == 1'b0) begin
          if (webA == 1'b0) begin
            for (int k = 0; k < 4; k++)
              if (maskA[k]) memA[b][addrA][8*k +: 8] <= dinA[8*k +: 8];
          end else begin
            rdA[b] <= memA[b][addrA];
          end
        end
      end
      for (int b = 0; b < 3; b++) begin
        pB0[b] <= junk;
        pB1[b] <= pB0[b];
        pB2[b] <= pB1[b];
        if (csbB[b] == 1'b0) begin
          if (webB == 1'b0) begin
            for (int k = 0; k < 4; k++)
              if (maskB[k]) memB[b][addrB][8*k +: 8] <= dinB[8*k +: 8];
          end else begin
            pB0[b] <= memB[b][addrB];
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cycleCount);
    end
  endtask

  // Reference: which slave owns an address, -1 when nobody does
  function automatic int slaveOf(input logic [31:0] a);
    if ((a & 32'hFFFF_E000) == BASE_A) return 0;
    if ((a & 32'hFFFF_C000) == BASE_B) return 1;
    return -1;
  endfunction

  function automatic logic isVoid(input logic [31:0] a);
    return (slaveOf(a) == 1) && (a[13:12] == 2'd3);
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (isVoid(a)) return 32'h0;
    if (refMem.exists(a[31:2])) return refMem[a[31:2]];
    return 32'h0;
  endfunction

  task automatic refWrite(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] cur;
    if (slaveOf(a) < 0 || isVoid(a)) return;
    cur = refRead(a);
    for (int k = 0; k < 4; k++) if (s[k]) cur[8*k +: 8] = d[8*k +: 8];
    refMem[a[31:2]] = cur;
  endtask

  function automatic logic [2:0] expCsb(input logic [31:0] a);
    logic [2:0] p;
    p = 3'b111;
    if (isVoid(a)) return p;
    if (slaveOf(a) == 0) p[a[12]] = 1'b0;
    else p[a[13:12]] = 1'b0;
    return p;
  endfunction

  // Drive one bus request; for hits predict the response, for misses expect silence
  task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [3:0] s,
                               input logic [31:0] d);
    exp_t e;
    int   n, sl;
    logic got;
    @(negedge clk);
    n = cycleCount + 1;
    issueSeq++;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    sl = slaveOf(a);
    if (sl >= 0) begin
      e.slave   = sl;
      e.isRead  = !w;
      e.voidAcc = isVoid(a);
      e.data    = w ? 32'h0 : refRead(a);
      e.csbEdge = n;
      e.ackEdge = (w || e.voidAcc) ? n + 1 : n + 1 + ((sl == 0) ? RL_A : RL_B);
      e.csbPat  = expCsb(a);
      e.word    = a[11:2];
      e.mask    = s;
      e.din     = d;
      expQ.push_back(e);
      if (w) refWrite(a, s, d);
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ackA || ackB) begin
        got = 1'b1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (sl < 0) begin
      checkOutput("miss_no_ack", 32'(got), 32'h0);
      checkOutput("miss_csb_A", obsCount[0], 0);
      checkOutput("miss_csb_B", obsCount[1], 0);
    end else if (!got) begin
      checkOutput("ack_timeout", 32'h0, 32'h1);
      if (expQ.size() > 0) void'(expQ.pop_back());
    end
  endtask

  // Start a hit request and drop cyc after 'dropAfter' cycles; no ack may follow
  task automatic abortStimulus(input logic [31:0] a, input logic w, input logic [31:0] d,
                               input int dropAfter, input logic resetInstead);
    int   sl;
    logic got;
    @(negedge clk);
    issueSeq++;
    cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; adr = a; wdat = d;
    sl = slaveOf(a);
    if (w) refWrite(a, 4'hF, d);
    repeat (dropAfter) @(negedge clk);
    if (resetInstead) begin
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_csb_A", 32'(csbA), 32'h3);
      checkOutput("rst_ack_A", 32'(ackA), 32'h0);
      checkOutput("rst_dat_A", datA, 32'h0);
      rst = 1'b0;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    got = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ackA || ackB) got = 1'b1;
    end
    checkOutput("abort_no_ack", 32'(got), 32'h0);
    checkOutput("abort_csb_count", obsCount[sl], isVoid(a) ? 0 : 1);
  endtask

  // Monitor: track macro enables and match every ack against the scoreboard
  int seenSeq = 0;
  initial begin
    exp_t e;
    logic [2:0] pat;
    int s;
    forever begin
      @(negedge clk);
      if (issueSeq != seenSeq) begin
        seenSeq = issueSeq;
        for (int i = 0; i < 2; i++) obsCount[i] = 0;
      end
      for (int i = 0; i < 2; i++) begin
        pat = (i == 0) ? {1'b1, csbA} : csbB;
        if (pat != 3'b111) begin
          obsCount[i]++;
          obsPat[i]  = pat;
          obsEdge[i] = cycleCount;
          obsWord[i] = (i == 0) ? addrA : addrB;
          obsMask[i] = (i == 0) ? maskA : maskB;
          obsWeb[i]  = (i == 0) ? webA : webB;
          obsDin[i]  = (i == 0) ? dinA : dinB;
        end
      end
      if (!rst && !initMem) begin
        if (!ackA) checkOutput("dat_idle_A", datA, 32'h0);
        if (!ackB) checkOutput("dat_idle_B", datB, 32'h0);
        if (ackA && ackB) begin
          checkOutput("double_ack", 32'h1, 32'h0);
        end else if (ackA || ackB) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_ack", 32'h1, 32'h0);
          end else begin
            e = expQ.pop_front();
            s = e.slave;
            checkOutput("ack_slave", ackB ? 32'h1 : 32'h0, 32'(e.slave));
            checkOutput("ack_edge", cycleCount, e.ackEdge);
            checkOutput("ack_data", ackB ? datB : datA, e.data);
            checkOutput("csb_count", obsCount[s], e.voidAcc ? 0 : 1);
            checkOutput("other_csb", obsCount[1-s], 0);
            if (!e.voidAcc) begin
              checkOutput("csb_bank", 32'(obsPat[s]), 32'(e.csbPat));
              checkOutput("csb_edge", obsEdge[s], e.csbEdge);
              checkOutput("sram_addr", 32'(obsWord[s]), 32'(e.word));
              checkOutput("sram_wmask", 32'(obsMask[s]), 32'(e.mask));
              checkOutput("sram_web", 32'(obsWeb[s]), 32'(e.isRead));
              if (!e.isRead) checkOutput("sram_din", obsDin[s], e.din);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          r;
    rst = 1'b1; initMem = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ack_A", 32'(ackA), 32'h0);
    checkOutput("reset_dat_A", datA, 32'h0);
    checkOutput("reset_csb_A", 32'(csbA), 32'h3);
    checkOutput("reset_web_A", 32'(webA), 32'h1);
    checkOutput("reset_wmask_A", 32'(maskA), 32'h0);
    checkOutput("reset_addr_A", 32'(addrA), 32'h0);
    checkOutput("reset_din_A", dinA, 32'h0);
    checkOutput("reset_ack_B", 32'(ackB), 32'h0);
    checkOutput("reset_csb_B", 32'(csbB), 32'h7);
    initMem = 1'b0;
    rst = 1'b0;

    $display("[TB] directed transfers");
    applyStimulus(BASE_A + 32'h0, 1'b1, 4'hF, 32'hDEADBEEF);
    applyStimulus(BASE_A + 32'h0, 1'b0, 4'hF, 32'h0);
    applyStimulus(BASE_A + 32'h1004, 1'b1, 4'b0010, 32'h0000AB00);
    applyStimulus(BASE_A + 32'h1004, 1'b0, 4'hF, 32'h0);
    applyStimulus(BASE_A + 32'h10000, 1'b0, 4'hF, 32'h0);
    applyStimulus(BASE_B + 32'h3000, 1'b0, 4'hF, 32'h0);
    applyStimulus(BASE_B + 32'h3008, 1'b1, 4'hF, 32'h12345678);
    applyStimulus(BASE_B + 32'h2010, 1'b1, 4'hF, 32'hCAFEF00D);
    applyStimulus(BASE_B + 32'h2010, 1'b0, 4'hF, 32'h0);
    applyStimulus(BASE_A + 32'h0, 1'b1, 4'b0000, 32'h11111111);
    applyStimulus(BASE_A + 32'h0, 1'b0, 4'hF, 32'h0);

    $display("[TB] aborts and reset");
    abortStimulus(BASE_B + 32'h2010, 1'b0, 32'h0, 2, 1'b0);
    applyStimulus(BASE_B + 32'h2010, 1'b0, 4'hF, 32'h0);
    abortStimulus(BASE_A + 32'h1008, 1'b1, 32'h5A5A_A5A5, 1, 1'b0);
    applyStimulus(BASE_A + 32'h1008, 1'b0, 4'hF, 32'h0);
    abortStimulus(BASE_A + 32'h1004, 1'b0, 32'h0, 2, 1'b0);
    abortStimulus(BASE_A + 32'h0004, 1'b0, 32'h0, 1, 1'b1);
    applyStimulus(BASE_A + 32'h1004, 1'b0, 4'hF, 32'h0);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 160; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = 32'h3001_0000 + ($urandom_range(0, 15) << 2);
      else if (r <= 5) a = BASE_A + ($urandom_range(0, 1) << 12) + ($urandom_range(0, 7) << 2);
      else a = BASE_B + ($urandom_range(0, 3) << 12) + ($urandom_range(0, 7) << 2);
      a = a + 32'($urandom_range(0, 3));
      applyStimulus(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    end

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
